dac_nch: RTL and testbench

Parametrised multi-channel behavioural DAC model for the sine-wave bench; successor to the single-channel 8-bit DAC model. Accepts channel-addressed codes over a valid/ready handshake, holds them in per-channel input registers, and after a fixed conversion latency transfers them to per-channel DAC registers whose values drive real-valued analog outputs. Supports auto-update per write or simultaneous (LDAC-style) update of all channels.

---
 rtl/dac_nch.sv | 158 +++++++++++++++
 tb/tb_dac_nch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_nch.sv
// rtl/dac_nch.sv - multi-channel behavioural DAC model with conversion latency and LDAC-style update
// Optional output slew limiting is enabled by defining DAC_SLEW_EN.
module dac_nch #(
    parameter int  WIDTH       = 8,
    parameter int  CHANNELS    = 4,
    parameter int  CONV_CYCLES = 3,
    parameter int  UPDATE_MODE = 0,
    parameter real Vref        = 3.3,
    parameter int  SLEW_LSB    = 16,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [CW-1:0]    s_chan,
    input  logic [WIDTH-1:0] s_data,
    input  logic             ldac,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             settled,
    output real              A_out [CHANNELS]
);

    localparam int  CNTW     = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(CONV_CYCLES - 1);
    localparam real SCALE    = Vref / (2.0 ** WIDTH);

    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
        $error("dac_nch: WIDTH must be 1..31");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("dac_nch: CHANNELS must be 1..16");
    end
    if (CONV_CYCLES < 1) begin : g_bad_conv
        $error("dac_nch: CONV_CYCLES must be >= 1");
    end
    if (SLEW_LSB < 1) begin : g_bad_slew
        $error("dac_nch: SLEW_LSB must be >= 1");
    end

    typedef enum logic {IDLE, CONV} state_t;

    state_t             state, state_nx;
    logic [CNTW-1:0]    cnt;
    logic               tgt_all;
    logic [CW-1:0]      tgt_chan;
    logic [WIDTH-1:0]   in_reg  [CHANNELS];
    logic [WIDTH-1:0]   dac_reg [CHANNELS];
    logic [WIDTH-1:0]   code    [CHANNELS];
    logic               chan_ok;
    logic               accept;
    logic               start;
    logic               finish;

    assign chan_ok = (int'(s_chan) < CHANNELS);
    assign busy    = (state == CONV);

    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        accept   = 1'b0;
        start    = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                s_ready = en && !rst;
                accept  = s_valid && s_ready;
                // mode 1 starts from ldac alone; a same-cycle write still lands first
                if (UPDATE_MODE == 0) start = accept && chan_ok;
                else                  start = en && ldac && !rst;
                if (start) state_nx = CONV;
            end
            CONV: begin
                finish = (cnt == '0);
                if (finish) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            tgt_all  <= 1'b0;
            tgt_chan <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                in_reg[c]  <= '0;
                dac_reg[c] <= '0;
            end
        end else begin
            state <= state_nx;
            done  <= finish;
            err   <= accept && !chan_ok;
            if (start) begin
                cnt      <= CNT_LOAD;
                tgt_all  <= (UPDATE_MODE != 0);
                tgt_chan <= s_chan;
            end else if (state == CONV && !finish) begin
                cnt <= cnt - 1'b1;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (accept && chan_ok && s_chan == CW'(c)) in_reg[c] <= s_data;
                if (finish && (tgt_all || tgt_chan == CW'(c))) dac_reg[c] <= in_reg[c];
            end
        end
    end

`ifdef DAC_SLEW_EN
    localparam logic [WIDTH:0] SLEW = (WIDTH + 1)'(SLEW_LSB);

    logic [WIDTH-1:0] out_code [CHANNELS];

    // each output chases its DAC register by at most SLEW per cycle, landing exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) out_code[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (dac_reg[c] > out_code[c]) begin
                    if ({1'b0, dac_reg[c]} - {1'b0, out_code[c]} > SLEW)
                        out_code[c] <= out_code[c] + SLEW[WIDTH-1:0];
                    else
                        out_code[c] <= dac_reg[c];
                end else if (dac_reg[c] < out_code[c]) begin
                    if ({1'b0, out_code[c]} - {1'b0, dac_reg[c]} > SLEW)
                        out_code[c] <= out_code[c] - SLEW[WIDTH-1:0];
                    else
                        out_code[c] <= dac_reg[c];
                end
            end
        end
    end

    always_comb begin
        settled = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            code[c] = out_code[c];
            if (out_code[c] != dac_reg[c]) settled = 1'b0;
        end
    end
`else
    always_comb begin
        settled = 1'b1;
        for (int c = 0; c < CHANNELS; c++) code[c] = dac_reg[c];
    end
`endif

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) A_out[c] = SCALE * real'(code[c]);
    end

endmodule

// File: tb/tb_dac_nch.sv
// tb/tb_dac_nch.sv - self-checking bench for dac_nch: directed vectors plus random traffic vs a reference model
// Three instances share stimulus: defaults (mode 0), mode 1 with 3 channels, mode 0 with 5 channels.
module tb_dac_nch;

    localparam int  NI   = 3;
    localparam int  CC   = 3;
    localparam real VREF = 3.3;
    localparam int  SLEW = 16;

    logic          clk = 1'b0;
    logic          rst, en, s_valid, ldac;
    logic [2:0]    s_chan;
    logic [7:0]    s_data;
    logic [NI-1:0] s_ready, busy, done, err, settled;
    real           a0 [4];
    real           a1 [3];
    real           a2 [5];

    int nchk = 0;
    int nerr = 0;

    int m_ir  [NI][16];
    int m_dr  [NI][16];
    int m_oc  [NI][16];
    int m_due [NI];
    int m_tgt [NI];
    bit m_done [NI];
    bit m_err  [NI];
    int edge_no = 0;

    typedef struct {
        logic [2:0] chan;
        logic [7:0] data;
        real        volts;
    } vec_t;
    vec_t vt [5];

    always #5 clk = ~clk;

    dac_nch u_a (
        .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready[0]),
        .s_chan(s_chan[1:0]), .s_data(s_data), .ldac(ldac), .busy(busy[0]),
        .done(done[0]), .err(err[0]), .settled(settled[0]), .A_out(a0)
    );
    dac_nch #(.CHANNELS(3), .UPDATE_MODE(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready[1]),
        .s_chan(s_chan[1:0]), .s_data(s_data), .ldac(ldac), .busy(busy[1]),
        .done(done[1]), .err(err[1]), .settled(settled[1]), .A_out(a1)
    );
    dac_nch #(.CHANNELS(5)) u_c (
        .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready[2]),
        .s_chan(s_chan), .s_data(s_data), .ldac(ldac), .busy(busy[2]),
        .done(done[2]), .err(err[2]), .settled(settled[2]), .A_out(a2)
    );

    function automatic int nch(int i);
        return (i == 0) ? 4 : (i == 1) ? 3 : 5;
    endfunction

    function automatic real aout(int i, int c);
        case (i)
            0:       return a0[c];
            1:       return a1[c];
            default: return a2[c];
        endcase
    endfunction

    task automatic chk_bit(string name, logic got, logic exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(string name, int got, int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_real(string name, real got, real exp, real tol);
        nchk++;
        if (got - exp > tol || exp - got > tol) begin
            nerr++;
            $display("FAIL %s: got %f expected %f at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset_inst(int i);
        for (int c = 0; c < 16; c++) begin
            m_ir[i][c] = 0;
            m_dr[i][c] = 0;
            m_oc[i][c] = 0;
        end
        m_due[i]  = 0;
        m_tgt[i]  = 0;
        m_done[i] = 0;
        m_err[i]  = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) model_reset_inst(i);
    endtask

    // one rising edge: m_due holds the edge number at which the pending update lands
    task automatic model_step();
        edge_no++;
        for (int i = 0; i < NI; i++) begin
            int ch;
            int diff;
            m_done[i] = 0;
            m_err[i]  = 0;
            if (rst) begin
                model_reset_inst(i);
                continue;
            end
            for (int c = 0; c < nch(i); c++) begin
                diff = m_dr[i][c] - m_oc[i][c];
                if (diff > SLEW)       m_oc[i][c] = m_oc[i][c] + SLEW;
                else if (diff < -SLEW) m_oc[i][c] = m_oc[i][c] - SLEW;
                else                   m_oc[i][c] = m_dr[i][c];
            end
            ch = (i == 2) ? int'(s_chan) : int'(s_chan[1:0]);
            if (m_due[i] != 0) begin
                if (m_due[i] == edge_no) begin
                    for (int c = 0; c < nch(i); c++)
                        if (m_tgt[i] < 0 || m_tgt[i] == c) m_dr[i][c] = m_ir[i][c];
                    m_done[i] = 1;
                    m_due[i]  = 0;
                end
            end else if (en) begin
                if (s_valid) begin
                    if (ch < nch(i)) begin
                        m_ir[i][ch] = int'(s_data);
                        if (i != 1) begin
                            m_due[i] = edge_no + CC;
                            m_tgt[i] = ch;
                        end
                    end else begin
                        m_err[i] = 1;
                    end
                end
                if (i == 1 && ldac) begin
                    m_due[i] = edge_no + CC;
                    m_tgt[i] = -1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            bit busy_m;
            bit settled_m;
            int code;
            busy_m    = (m_due[i] != 0);
            settled_m = 1'b1;
            chk_bit($sformatf("busy%0d", i), busy[i], busy_m);
            chk_bit($sformatf("s_ready%0d", i), s_ready[i], !rst && en && !busy_m);
            chk_bit($sformatf("done%0d", i), done[i], m_done[i]);
            chk_bit($sformatf("err%0d", i), err[i], m_err[i]);
            for (int c = 0; c < nch(i); c++) begin
`ifdef DAC_SLEW_EN
                code = m_oc[i][c];
                if (m_oc[i][c] != m_dr[i][c]) settled_m = 1'b0;
`else
                code = m_dr[i][c];
`endif
                chk_real($sformatf("a_out%0d[%0d]", i, c), aout(i, c), VREF * code / 256.0, 1e-9);
            end
            chk_bit($sformatf("settled%0d", i), settled[i], settled_m);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        tick();
        rst = 1'b0;
    endtask

    task automatic settle();
`ifdef DAC_SLEW_EN
        for (int t = 0; t < 40 && settled != '1; t++) tick();
        chk_bit("settle_timeout", &settled, 1'b1);
`endif
    endtask

    initial begin
        int n;
        int k;
        vt[0] = '{3'd1, 8'h80, 1.65};
        vt[1] = '{3'd3, 8'hFF, 3.2871};
        vt[2] = '{3'd0, 8'h40, 0.825};
        vt[3] = '{3'd2, 8'hC0, 2.475};
        vt[4] = '{3'd1, 8'h00, 0.0};

        rst = 1'b1; en = 1'b0; s_valid = 1'b0; ldac = 1'b0; s_chan = '0; s_data = '0;
        model_reset();
        #1;
        check_all();
        en = 1'b1;
        #1;
        chk_bit("ready_in_reset", s_ready[0], 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_bit("ready_after_reset", s_ready[0], 1'b1);
        chk_real("reset_aout", a0[3], 0.0, 1e-9);

        // mode 0 directed writes on the default instance
        for (int v = 0; v < 5; v++) begin
            s_valid = 1'b1; s_chan = vt[v].chan; s_data = vt[v].data;
            tick();
            s_valid = 1'b0;
            n = 0;
            while (!done[0] && n < 10) begin
                tick();
                n++;
            end
            chk_int($sformatf("latency_v%0d", v), n, CC);
            settle();
            chk_real($sformatf("volts_v%0d", v), aout(0, int'(vt[v].chan[1:0])), vt[v].volts, 1e-3);
            tick();
        end

        // mode 1: staged writes, then one ldac updates both; ldac during CONV is dropped
        do_reset();
        s_valid = 1'b1; s_chan = 3'd0; s_data = 8'h40;
        tick();
        s_chan = 3'd2; s_data = 8'hC0;
        tick();
        s_valid = 1'b0;
        tick();
        chk_real("m1_hold_ch0", a1[0], 0.0, 1e-9);
        chk_real("m1_hold_ch2", a1[2], 0.0, 1e-9);
        ldac = 1'b1;
        tick();
        n = 0; k = 0;
        for (int t = 0; t < 12; t++) begin
            if (t == 2) ldac = 1'b0;
            tick();
            if (done[1]) begin
                k++;
                if (n == 0) n = t + 1;
            end
        end
        chk_int("m1_latency", n, CC);
        chk_int("m1_done_count", k, 1);
        settle();
        chk_real("m1_ch0", a1[0], 0.825, 1e-3);
        chk_real("m1_ch2", a1[2], 2.475, 1e-3);

        // write and ldac in the same cycle: the write joins that update
        s_valid = 1'b1; s_chan = 3'd1; s_data = 8'h20; ldac = 1'b1;
        tick();
        s_valid = 1'b0; ldac = 1'b0;
        for (int t = 0; t < CC + 1; t++) tick();
        settle();
        chk_real("m1_same_cycle", a1[1], 0.4125, 1e-3);

        // out-of-range channel
        do_reset();
        s_valid = 1'b1; s_chan = 3'd5; s_data = 8'h77;
        tick();
        s_valid = 1'b0;
        chk_bit("err_pulse_c", err[2], 1'b1);
        chk_bit("err_no_busy_c", busy[2], 1'b0);
        tick();
        chk_bit("err_drop_c", err[2], 1'b0);
        chk_real("err_aout_c", a2[0], 0.0, 1e-9);
        s_valid = 1'b1; s_chan = 3'd3;
        tick();
        s_valid = 1'b0;
        chk_bit("err_pulse_b", err[1], 1'b1);
        for (int t = 0; t < 5; t++) tick();

        // reset in the middle of a conversion discards it
        do_reset();
        s_valid = 1'b1; s_chan = 3'd0; s_data = 8'hFF;
        tick();
        s_valid = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk_real("rst_mid_aout", a0[0], 0.0, 1e-9);
        tick();
        rst = 1'b0;
        k = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (done[0]) k++;
        end
        chk_int("rst_mid_no_done", k, 0);
        chk_real("rst_mid_aout_after", a0[0], 0.0, 1e-9);

        // random traffic against the model
        for (int t = 0; t < 600; t++) begin
            en      = ($urandom % 8) != 0;
            s_valid = $urandom % 2;
            s_chan  = 3'($urandom % 8);
            s_data  = 8'($urandom);
            ldac    = ($urandom % 4) == 0;
            if ($urandom % 80 == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                check_all();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
